// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests,
// registered IF/ID output with a one-entry skid and redirect flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        sk_valid_q, sk_valid_d;
  logic [31:0] sk_inst_q, sk_inst_d;
  logic [31:0] sk_pc_q, sk_pc_d;

  logic req_fire;
  logic consume;

  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && !rst;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign consume        = id_valid_q && id_ready;

  assign id_valid = id_valid_q;
  assign id_inst  = id_valid_q ? id_inst_q : NOP_INST;
  assign id_pc    = id_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    sk_valid_d = sk_valid_q;
    sk_inst_d  = sk_inst_q;
    sk_pc_d    = sk_pc_q;

    if (consume) id_valid_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          pc_d = fetch_pc_q + 32'd4;
          if (!id_valid_q || id_ready) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rsp_data;
            id_pc_d    = fetch_pc_q;
            state_d    = S_REQ;
          end else begin
            sk_valid_d = 1'b1;
            sk_inst_d  = imem_rsp_data;
            sk_pc_d    = fetch_pc_q;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready && sk_valid_q) begin
          id_valid_d = 1'b1;
          id_inst_d  = sk_inst_q;
          id_pc_d    = sk_pc_q;
          sk_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A still-outstanding response must be swallowed before refetching.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'd3;
      id_valid_d = 1'b0;
      sk_valid_d = 1'b0;
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rsp_valid)
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      sk_valid_q <= 1'b0;
      sk_inst_q  <= NOP_INST;
      sk_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      sk_valid_q <= sk_valid_d;
      sk_inst_q  <= sk_inst_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic,
// checked by an in-order scoreboard of the expected instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Stream restarts at pc: everything earlier is flushed.
  function automatic void refill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      exp_q.push_back('{pc: p, inst: mem_word(p)});
      p = p + 32'd4;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) refill(RESET_PC);
    else if (redirect_valid) refill(redirect_pc & ~32'd3);
    redirect_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    item_t       e;
    prev_stall = 1'b0;
    prev_pc = '0;
    prev_inst = '0;
    forever begin
      @(negedge clk);
      if (rst || redirect_valid)
        check("no_req_rst_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid)
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (id_valid === 1'b0)
        check("nop_when_empty", id_inst, NOP);
      if (prev_stall) begin
        check("stall_valid", 32'(id_valid), 32'd1);
        check("stall_pc", id_pc, prev_pc);
        check("stall_inst", id_inst, prev_inst);
      end
      if (!rst && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected no delivery", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", id_pc, e.pc);
          check("sb_inst", id_inst, e.inst);
          delivered++;
        end
      end
      prev_stall = !rst && !redirect_valid && id_valid && !id_ready;
      prev_pc = id_pc;
      prev_inst = id_inst;
    end
  end

  // Memory model: random latency, one response per accepted request.
  initial begin
    logic        acc, r, rv, busy;
    logic [31:0] a, rt, out_addr, exp_addr;
    int          cnt;
    busy = 1'b0;
    cnt = 0;
    out_addr = '0;
    exp_addr = RESET_PC;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      a = imem_addr;
      r = rst;
      rv = redirect_valid;
      rt = redirect_pc;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
      if (r) begin
        busy = 1'b0;
        exp_addr = RESET_PC;
      end else begin
        if (rv) exp_addr = rt & ~32'd3;
        if (acc) begin
          check("req_addr", a, exp_addr);
          check("one_outstanding", 32'(busy), 32'd0);
          exp_addr = exp_addr + 32'd4;
          busy = 1'b1;
          out_addr = a;
          cnt = $urandom_range(lat_hi, lat_lo);
        end
      end
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          busy = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_data = mem_word(out_addr);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic found;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    tick();
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 32'd0);
    tick();
    rst = 1'b0;
    id_ready = 1'b0;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("lat_empty", 32'(id_valid), 32'd0);
      if (c == 0) begin
        check("first_req", 32'(imem_req_valid), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
      end
      tick();
    end
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(id_valid), 32'd1);
      check("stall_hold_pc", id_pc, 32'd0);
      if (c == 2) check("first_inst", id_inst, mem_word(32'd0));
      if (c >= 3) check("hold_no_req", 32'(imem_req_valid), 32'd0);
      tick();
    end
    id_ready = 1'b1;
    lat_lo = 3;
    lat_hi = 3;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("release_valid", 32'(id_valid), 32'd1);
    check("release_pc", id_pc, 32'd4);
    check("req8_valid", 32'(imem_req_valid), 32'd1);
    check("req8_addr", imem_addr, 32'd8);
    tick();

    // Redirect while waiting on address 8
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("redir_wait_idv", 32'(id_valid), 32'd0);
    tick();
    lat_lo = 1;
    lat_hi = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid) found = 1'b1;
      else begin
        check("drop_idv", 32'(id_valid), 32'd0);
        tick();
      end
    end
    check("drop_req_seen", 32'(found), 32'd1);
    check("drop_target", imem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      @(negedge clk);
      if (id_valid) found = 1'b1;
    end
    check("target_delivered", 32'(found), 32'd1);
    check("target_pc", id_pc, 32'h0000_0100);

    // Redirect in the same cycle as a response
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) found = 1'b1;
    end
    check("accept_seen", 32'(found), 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    @(negedge clk);
    check("rsp_redir_rsp", 32'(imem_rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    check("rsp_redir_req", 32'(imem_req_valid), 32'd1);
    check("rsp_redir_addr", imem_addr, 32'h0000_2000);

    // Redirect in REQ with ready high
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("req_redir_req", 32'(imem_req_valid), 32'd1);
    check("req_redir_addr", imem_addr, 32'h0000_3000);

    // Wrap at top of address space
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      @(negedge clk);
      if (id_valid && id_pc == 32'd0) found = 1'b1;
    end
    check("wrap_to_zero", 32'(found), 32'd1);

    // Reset while holding a full skid
    tick();
    id_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("hold_full_valid", 32'(id_valid), 32'd1);
    check("hold_full_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    check("hold_rst_idv", 32'(id_valid), 32'd0);
    check("hold_rst_inst", id_inst, NOP);
    check("hold_rst_pc", id_pc, 32'd0);
    check("hold_rst_req", 32'(imem_req_valid), 32'd1);
    check("hold_rst_addr", imem_addr, RESET_PC);
    tick();

    // Randomized traffic
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      id_ready = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (!rst && $urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end
      tick();
    end
    rst = 1'b0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (20) tick();
    check("liveness", 32'(delivered > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
